// File: rtl/cpu_dbg_pkg.sv
// Shared debug-controller definitions: FSM states and register-index constants.
package cpu_dbg_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] PC_TAG = '0;

  typedef enum logic [2:0] {
    RSC_IDLE,
    RSC_RUN,
    RSC_CAPPC,
    RSC_SEND,
    RSC_SEL
  } rsc_state_e;

endpackage

// File: rtl/rsc_down_counter.sv
// Loadable down-counter that saturates at zero; used for run length and settle time.
module rsc_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   count <= '0;
    else if (load)             count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/regscan_ctrl.sv
// Run/scan controller: runs the CPU for N cycles, freezes it, then streams PC
// and a register range out as a valid/ready word stream.
module regscan_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int RUN_W     = 16,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int SETTLE    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RUN_W-1:0]     run_cycles,
  output logic                 cpu_rstn,
  output logic                 cpu_en,
  output logic [REG_IDX_W-1:0] reg_sel,
  input  logic [31:0]          reg_data,
  input  logic [31:0]          pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_idx,
  output logic [31:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);
  localparam logic [RUN_W-1:0]     SETTLE_LD = RUN_W'(SETTLE - 1);

  rsc_state_e       state, nxt;
  logic             accept;
  logic             run_load, run_en, run_zero;
  logic             set_load, set_en, set_zero;
  logic [RUN_W-1:0] run_ld_val;
  logic             on_pc;

  // Counter holds "cycles remaining after this one", so RUN exits when it reads zero.
  assign run_ld_val = (run_cycles == '0) ? '0 : run_cycles - 1'b1;

  rsc_down_counter #(.W(RUN_W)) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .en       (run_en),
    .load_val (run_ld_val),
    .zero     (run_zero)
  );

  rsc_down_counter #(.W(RUN_W)) u_set_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (set_load),
    .en       (set_en),
    .load_val (SETTLE_LD),
    .zero     (set_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RSC_IDLE;
    else     state <= nxt;
  end

  // Next-state and per-state strobes; cpu_en and out_valid come straight from the state.
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    cpu_en    = 1'b0;
    out_valid = 1'b0;
    run_load  = 1'b0;
    run_en    = 1'b0;
    set_load  = 1'b0;
    set_en    = 1'b0;
    case (state)
      RSC_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          run_load = 1'b1;
          nxt      = (run_cycles == '0) ? RSC_CAPPC : RSC_RUN;
        end
      end
      RSC_RUN: begin
        cpu_en = 1'b1;
        run_en = 1'b1;
        if (run_zero) nxt = RSC_CAPPC;
      end
      RSC_CAPPC: nxt = RSC_SEND;
      RSC_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          nxt      = out_last ? RSC_IDLE : RSC_SEL;
          set_load = ~out_last;
        end
      end
      RSC_SEL: begin
        set_en = 1'b1;
        if (set_zero) nxt = RSC_SEND;
      end
      default: nxt = RSC_IDLE;
    endcase
  end

  assign busy = (state != RSC_IDLE);

  // Output word, register select, sticky CPU reset release and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rstn <= 1'b0;
      reg_sel  <= '0;
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
      on_pc    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) cpu_rstn <= 1'b1;
      case (state)
        RSC_CAPPC: begin
          out_data <= pc;
          out_idx  <= PC_TAG;
          out_last <= 1'b0;
          on_pc    <= 1'b1;
        end
        RSC_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              done    <= 1'b1;
              reg_sel <= '0;
            end else begin
              reg_sel <= on_pc ? FIRST_IDX : reg_sel + 1'b1;
            end
          end
        end
        RSC_SEL: begin
          if (set_zero) begin
            out_data <= reg_data;
            out_idx  <= reg_sel;
            out_last <= (reg_sel == LAST_IDX);
            on_pc    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regscan_ctrl.md
# regscan_ctrl

Debug run/scan controller for the 5-stage pipelined RISC-V CPU top (`sccomp`). On a start pulse it releases the CPU from reset and runs it for a programmed number of clock cycles. It then freezes the pipeline through a clock enable and walks the CPU's register-file debug port (`reg_sel`/`reg_data`). The captured PC and registers are streamed out as a valid/ready word stream, so board logic and benches can take architectural snapshots without hand-sequencing `reg_sel`.

## Interface
- `RUN_W`, 16: width of the run-cycle counter.
- `FIRST_REG`, 1: first register index scanned.
- `LAST_REG`, 31: last register index scanned; `FIRST_REG <= LAST_REG <= 31`.
- `SETTLE`, 1: cycles `reg_sel` is held before `reg_data` is sampled; must be ≥1.

Ports:
- `clk`  in  1  system clock; CPU and controller share it.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `run_cycles`  in  RUN_W  CPU cycles to run; latched on accepted `start`.
- `cpu_rstn`  out  1  active-low reset to the CPU.
- `cpu_en`  out  1  pipeline clock enable; 0 freezes all CPU state.
- `reg_sel`  out  5  register-file debug select.
- `reg_data`  in  32  register-file debug read data (combinational from `reg_sel`).
- `pc`  in  32  CPU `PC_out`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream word accepted.
- `out_idx`  out  5  word tag: 0 = PC, else register index.
- `out_data`  out  32  word payload.
- `out_last`  out  1  final word of snapshot.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after final handshake.

## Operation
- FSM states: IDLE, RUN, CAPPC, SEND, SEL.
- **IDLE.** Output values:
  - `cpu_en=0`, `reg_sel=0`, `out_valid=0`.
  - An accepted `start` latches `run_cycles` and sets the sticky `cpu_rstn=1`.
  - Next state is RUN, or CAPPC when `run_cycles==0`.
- **RUN.** `cpu_en=1` for exactly `run_cycles` cycles, using a down-counter. Next state is CAPPC.
- **CAPPC.** `cpu_en=0`. Registers `out_data<=pc` and `out_idx<=0`. Next state is SEND.
- **SEND.** `out_valid=1`, and data/idx/last stay stable until `out_valid&&out_ready`. On the handshake:
  - If this was the last word, go to IDLE and pulse `done`.
  - Otherwise go to SEL with `reg_sel` = next index. After the PC word, the next index is `FIRST_REG`.
- **SEL.** Holds `reg_sel` for `SETTLE` cycles. On the last SEL cycle it registers `out_data<=reg_data`, `out_idx<=reg_sel` and `out_last<=(reg_sel==LAST_REG)`, then goes to SEND.
- Snapshot word count is `1+LAST_REG-FIRST_REG+1`; 32 at the defaults.
- Frozen pipeline: in-flight instructions stay in their stages. A later `start` resumes them with `cpu_rstn` still 1, so the CPU is not reset.
- `cpu_rstn` returns to 0 only on `rst`.
- `start` while `busy` is ignored, with no queuing.
- `out_ready` outside SEND is ignored.
- `run_cycles` at the maximum value (`2^RUN_W-1`) runs that many cycles with no wrap.

## Timing
- Reset values: `cpu_rstn=0`, `cpu_en=0`, `reg_sel=0`, `out_valid=0`, `out_idx=0`, `out_data=0`, `out_last=0`, `busy=0`, `done=0`, FSM=IDLE, counters=0.
- `rst` mid-operation aborts at once:
  - All outputs return to their reset values.
  - Any partial snapshot is discarded.
  - The CPU is re-held in reset.
- `start` sampled at cycle 0 gives `cpu_en` high during cycles 1..N. CAPPC is at N+1 and the first `out_valid` is at N+2.
- With `out_ready` tied high:
  - Each register costs `SETTLE+1` cycles.
  - The last SEND is at cycle N+2+(LAST_REG-FIRST_REG+1)(SETTLE+1).
  - `done` follows one cycle later.
- Defaults with N=10: final word at cycle 74, `done` at 75.
- Backpressure stalls only SEND. `reg_sel` is not advanced while a word is pending.
- `cpu_en` is never high outside RUN.

## Structure
- The shared package `cpu_dbg_pkg` holds:
  - the state enum (`RSC_IDLE` … `RSC_SEL`),
  - the register-index width constant (5),
  - `PC_TAG=0`.
- A sub-module `rsc_down_counter` (load, enable, zero flag, width `RUN_W`) is used for both the run counter and the settle counter.
- Everything else is a single FSM module.

## Test plan
- **Basic snapshot.** Program `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2`, start with `run_cycles=20`, `out_ready=1`. Expect:
  - 32 words, `idx` 0..31 in order.
  - x1=5, x2=7, x3=12.
  - `out_last` only on idx 31.
  - `done` at cycle 85.
- **Backpressure.** Same run with `out_ready` toggled every other cycle. Expect:
  - identical word sequence;
  - `out_data`/`out_idx` stable while valid and not ready;
  - `reg_sel` unchanged during stalls.
- **Zero run.** `run_cycles=0` straight after reset. Expect:
  - `cpu_en` never high;
  - the PC word is the CPU reset PC;
  - all registers read 0.
- **Resume.** Run with N=3, then a second start with N=20. Expect:
  - `cpu_rstn` stays 1 between the two runs;
  - the second snapshot matches an uninterrupted N=23 run.
- **Busy start / abort.** A `start` in mid-scan is ignored. Asserting `rst` at word 10 forces:
  - all outputs to reset values on the same cycle;
  - the next `start` to produce a full 32-word snapshot.
- **Parameter sweep.** Set `FIRST_REG=5`, `LAST_REG=8`, `SETTLE=3`. Expect:
  - 5 words with idx 0,5,6,7,8;
  - each `reg_sel` held 3 cycles before its SEND.
